instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Program-counter and IF/ID fetch stage for the MIPS datapath.
- Generates the byte address driven into the instruction ROM's address input (text base 0x0040_0000) and takes the ROM's combinational instruction back on the same cycle.
- Registers the instruction together with PC+4 into the IF/ID pipeline register.
- Selects the next PC from sequential, branch, jump and jump-register sources, with stall, flush and address-error handling.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- MEMORY_DEPTH, 64, number of instruction words in the ROM; sets the legal fetch window.
- RESET_PC, 32'h0040_0000, PC value after reset; also the base of the legal fetch window.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on bubble.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset.
- Stall_i  in  1  hold PC and IF/ID (hazard unit).
- Flush_i  in  1  replace the next IF/ID capture with a bubble.
- Branch_Taken_i  in  1  redirect to Branch_Target_i.
- Branch_Target_i  in  DATA_WIDTH  branch byte address.
- Jump_i  in  1  J/JAL redirect.
- Jump_Index_i  in  26  instr_index field from ID.
- Jr_i  in  1  JR redirect.
- Jr_Target_i  in  DATA_WIDTH  register-file value for JR.
- Instruction_i  in  DATA_WIDTH  ROM output for the current PC_o.
- PC_o  out  DATA_WIDTH  current PC, connected to the ROM address input.
- IF_ID_Instruction_o  out  DATA_WIDTH  registered instruction.
- IF_ID_PC_Plus4_o  out  DATA_WIDTH  registered PC+4 of that instruction.
- IF_ID_Valid_o  out  1  IF/ID holds a real instruction.
- Addr_Error_o  out  1  sticky fetch-address fault.

Behaviour:
- All state updates on the rising clk edge. reset==0 at an edge forces:
  - PC_o=RESET_PC
  - IF_ID_Instruction_o=NOP_WORD
  - IF_ID_PC_Plus4_o=0
  - IF_ID_Valid_o=0
  - Addr_Error_o=0
- Reset overrides every other input.
- In-range test: PC_o is in range when RESET_PC <= PC_o < RESET_PC+4*MEMORY_DEPTH and PC_o[1:0]==0.
- Next-PC priority, highest first:
  - Jr_i: Jr_Target_i.
  - Jump_i: {IF_ID_PC_Plus4_o[31:28], Jump_Index_i, 2'b00}.
  - Branch_Taken_i: Branch_Target_i.
  - Otherwise PC_o+4, modulo 2^32.
- Redirects are applied even when Stall_i=1. A redirect at the same edge as a stall updates the PC and forces a bubble into IF/ID.
- Stall_i=1 with no redirect:
  - PC_o holds.
  - IF/ID holds all three fields.
  - Addr_Error_o holds.
- Capture with no stall: IF_ID_Instruction_o<=Instruction_i, IF_ID_PC_Plus4_o<=PC_o+4, IF_ID_Valid_o<=1. The exceptions below override this.
  - Flush_i=1 or any redirect active: IF/ID<=NOP_WORD, Valid<=0, PC_Plus4<=PC_o+4.
  - PC_o out of range: IF/ID<=NOP_WORD, Valid<=0, Addr_Error_o<=1.
- Selected next PC with bits[1:0]!=0: those bits are cleared before loading and Addr_Error_o<=1.
- Addr_Error_o is sticky; only reset clears it. Fetching continues after an error; the PC still advances by +4.
- Fetch latency is 1 cycle: the instruction at PC_o appears on IF_ID_Instruction_o after the next edge.
- Fall-through past the last ROM word (PC_o=RESET_PC+4*(MEMORY_DEPTH-1) followed by +4) leaves the window. The next capture is a bubble with Addr_Error_o=1.
- PC wrap 0xFFFF_FFFC+4 gives 0x0000_0000, which is out of range.
- No combinational path from Instruction_i to PC_o.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. Required: PC_o=0x0040_0000 during reset; after the first edge with reset=1, IF_ID_Instruction_o=rom[0], IF_ID_PC_Plus4_o=0x0040_0004, Valid=1, PC_o=0x0040_0004.
- Stall: Stall_i=1 for 3 cycles at PC_o=0x0040_0008. Required: PC_o and all IF/ID fields unchanged for the 3 cycles; the next edge resumes with rom[2] captured.
- Redirect priority: Jr_i=1 (0x0040_0040), Jump_i=1 and Branch_Taken_i=1 (0x0040_0020) all asserted together. Required: PC_o=0x0040_0040, IF/ID bubble (Valid=0, NOP).
- Jump formation: IF_ID_PC_Plus4_o=0x0040_0010 with Jump_Index_i=0x010_0005. Required: PC_o=0x0040_0014.
- Redirect while stalled: Stall_i=1 and Branch_Taken_i=1 to 0x0040_0030. Required: PC_o=0x0040_0030, Valid=0.
- Faults: Branch_Target_i=0x0040_0006 gives PC_o=0x0040_0004 and Addr_Error_o=1. After reset, sequential run to PC_o=0x0040_0100 (MEMORY_DEPTH=64) gives a NOP bubble with Valid=0 and Addr_Error_o=1, which stays set until reset.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Program counter and IF/ID pipeline register for the MIPS fetch stage.
// Drives the ROM byte address and registers the returned word together with PC+4.
// Picks the next PC from these sources: JR, then J/JAL, then a taken branch, then PC+4.
// Also handles stall, flush, bubbles on redirect and a sticky address-error flag.
module instruction_fetch_unit #(
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter int unsigned          MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  input  logic                  Branch_Taken_i,
  input  logic [DATA_WIDTH-1:0] Branch_Target_i,
  input  logic                  Jump_i,
  input  logic [25:0]           Jump_Index_i,
  input  logic                  Jr_i,
  input  logic [DATA_WIDTH-1:0] Jr_Target_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
  output logic [DATA_WIDTH-1:0] IF_ID_PC_Plus4_o,
  output logic                  IF_ID_Valid_o,
  output logic                  Addr_Error_o
);

  localparam logic [DATA_WIDTH-1:0] PcStep = DATA_WIDTH'(4);
  // The window bounds are one bit wider, so the upper limit cannot overflow.
  localparam logic [DATA_WIDTH:0]   WinLo  = {1'b0, RESET_PC};
  localparam logic [DATA_WIDTH:0]   WinHi  = WinLo + (DATA_WIDTH + 1)'(4 * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  redirect;
  logic                  in_range;
  logic                  misaligned;

  // Decode the fetch window and the prioritised next-PC source.
  always_comb begin
    pc_plus4   = pc_q + PcStep;
    in_range   = ({1'b0, pc_q} >= WinLo) && ({1'b0, pc_q} < WinHi) && (pc_q[1:0] == 2'b00);
    redirect   = Jr_i || Jump_i || Branch_Taken_i;
    if (Jr_i) begin
      next_pc = Jr_Target_i;
    end else if (Jump_i) begin
      next_pc = {pc4_q[DATA_WIDTH-1:28], Jump_Index_i, 2'b00};
    end else if (Branch_Taken_i) begin
      next_pc = Branch_Target_i;
    end else begin
      next_pc = pc_plus4;
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

  // Next-state for the PC, the IF/ID fields and the error flag.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    // A redirect overrides a stall. Only a plain stall freezes everything.
    if (!Stall_i || redirect) begin
      pc_d  = {next_pc[DATA_WIDTH-1:2], 2'b00};
      pc4_d = pc_plus4;
      if (redirect || Flush_i || !in_range) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d = Instruction_i;
        valid_d = 1'b1;
      end
      if (!in_range || misaligned) begin
        err_d = 1'b1;
      end
    end
  end

  // Fetch state registers with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign PC_o                = pc_q;
  assign IF_ID_Instruction_o = instr_q;
  assign IF_ID_PC_Plus4_o    = pc4_q;
  assign IF_ID_Valid_o       = valid_q;
  assign Addr_Error_o        = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// A behavioural model and a ROM stand-in are checked every cycle.
// Directed literal checks pin the model to hand-computed values.
module tb_instruction_fetch_unit;

  localparam logic [31:0] Base = 32'h0040_0000;
  localparam int unsigned Depth = 64;
  localparam logic [31:0] Nop = 32'h0000_0000;
  localparam logic [31:0] Junk = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall_i, Flush_i, Branch_Taken_i, Jump_i, Jr_i;
  logic [31:0] Branch_Target_i, Jr_Target_i, Instruction_i;
  logic [25:0] Jump_Index_i;
  logic [31:0] PC_o, IF_ID_Instruction_o, IF_ID_PC_Plus4_o;
  logic        IF_ID_Valid_o, Addr_Error_o;

  logic [31:0] rom [Depth];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state.
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_val, m_err;
  logic [31:0] m_tgt;
  bit          m_redir, m_inr;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .Stall_i             (Stall_i),
    .Flush_i             (Flush_i),
    .Branch_Taken_i      (Branch_Taken_i),
    .Branch_Target_i     (Branch_Target_i),
    .Jump_i              (Jump_i),
    .Jump_Index_i        (Jump_Index_i),
    .Jr_i                (Jr_i),
    .Jr_Target_i         (Jr_Target_i),
    .Instruction_i       (Instruction_i),
    .PC_o                (PC_o),
    .IF_ID_Instruction_o (IF_ID_Instruction_o),
    .IF_ID_PC_Plus4_o    (IF_ID_PC_Plus4_o),
    .IF_ID_Valid_o       (IF_ID_Valid_o),
    .Addr_Error_o        (Addr_Error_o)
  );

  function automatic bit legal(input logic [31:0] a);
    return (a >= Base) && (a < Base + 4 * Depth) && (a % 4 == 0);
  endfunction

  // Outside the window the ROM returns junk, so a missing bubble is visible.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (legal(a)) return rom[(a - Base) / 4];
    return Junk;
  endfunction

  assign Instruction_i = rom_word(PC_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one fetch decision per rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      m_pc = Base; m_ins = Nop; m_pc4 = 0; m_val = 0; m_err = 0;
    end else begin
      m_redir = Jr_i || Jump_i || Branch_Taken_i;
      m_inr   = legal(m_pc);
      if (Jr_i)                m_tgt = Jr_Target_i;
      else if (Jump_i)         m_tgt = {m_pc4[31:28], Jump_Index_i, 2'b00};
      else if (Branch_Taken_i) m_tgt = Branch_Target_i;
      else                     m_tgt = m_pc + 4;
      if (m_redir || !Stall_i) begin
        if (m_redir || Flush_i || !m_inr) begin
          m_ins = Nop; m_val = 0;
        end else begin
          m_ins = rom_word(m_pc); m_val = 1;
        end
        m_pc4 = m_pc + 4;
        if (!m_inr || (m_tgt % 4 != 0)) m_err = 1;
        m_pc = m_tgt - (m_tgt % 4);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", PC_o, m_pc);
      check("ifid_instr", IF_ID_Instruction_o, m_ins);
      check("ifid_pc4", IF_ID_PC_Plus4_o, m_pc4);
      check("ifid_valid", 32'(IF_ID_Valid_o), 32'(m_val));
      check("addr_err", 32'(Addr_Error_o), 32'(m_err));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    Stall_i = 0; Flush_i = 0; Branch_Taken_i = 0; Jump_i = 0; Jr_i = 0;
    Branch_Target_i = 0; Jr_Target_i = 0; Jump_Index_i = 0;
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) rom[i] = 32'h2000_0000 + 32'(i) * 32'h0001_0103;
    idle();
    reset = 0;
    step();
    chk_en = 1;
    step();
    check("lit_reset_pc", PC_o, 32'h0040_0000);
    check("lit_reset_valid", 32'(IF_ID_Valid_o), 32'd0);
    reset = 1;
    step();
    check("lit_first_instr", IF_ID_Instruction_o, rom[0]);
    check("lit_first_pc4", IF_ID_PC_Plus4_o, 32'h0040_0004);
    check("lit_first_valid", 32'(IF_ID_Valid_o), 32'd1);
    check("lit_first_pc", PC_o, 32'h0040_0004);
    step();
    check("lit_pre_stall_pc", PC_o, 32'h0040_0008);
    // Plain stall for three cycles.
    Stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lit_stall_pc", PC_o, 32'h0040_0008);
      check("lit_stall_instr", IF_ID_Instruction_o, rom[1]);
      check("lit_stall_pc4", IF_ID_PC_Plus4_o, 32'h0040_0008);
    end
    Stall_i = 0;
    step();
    check("lit_resume_instr", IF_ID_Instruction_o, rom[2]);
    check("lit_resume_pc", PC_o, 32'h0040_000C);
    // Flush inserts a bubble but keeps PC+4.
    Flush_i = 1;
    step();
    check("lit_flush_valid", 32'(IF_ID_Valid_o), 32'd0);
    check("lit_flush_pc4", IF_ID_PC_Plus4_o, 32'h0040_0010);
    Flush_i = 0;
    // The jump takes PC[31:28] from IF/ID PC+4 (0x0040_0010).
    Jump_i = 1; Jump_Index_i = 26'h010_0005;
    step();
    check("lit_jump_pc", PC_o, 32'h0040_0014);
    check("lit_jump_valid", 32'(IF_ID_Valid_o), 32'd0);
    idle();
    // All redirects at once: JR wins.
    Jr_i = 1; Jr_Target_i = 32'h0040_0040;
    Jump_i = 1; Jump_Index_i = 26'h000_0001;
    Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0020;
    step();
    check("lit_prio_pc", PC_o, 32'h0040_0040);
    check("lit_prio_instr", IF_ID_Instruction_o, Nop);
    check("lit_prio_valid", 32'(IF_ID_Valid_o), 32'd0);
    idle();
    step();
    check("lit_jr_fetch", IF_ID_Instruction_o, rom[16]);
    // A redirect during a stall still moves the PC.
    Stall_i = 1; Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0030;
    step();
    check("lit_stallbr_pc", PC_o, 32'h0040_0030);
    check("lit_stallbr_valid", 32'(IF_ID_Valid_o), 32'd0);
    idle();
    step();
    check("lit_br_fetch", IF_ID_Instruction_o, rom[12]);
    check("lit_no_err", 32'(Addr_Error_o), 32'd0);
    // A misaligned target has its low bits dropped and raises an error.
    Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0006;
    step();
    check("lit_mis_pc", PC_o, 32'h0040_0004);
    check("lit_mis_err", 32'(Addr_Error_o), 32'd1);
    idle();
    step();
    check("lit_err_sticky", 32'(Addr_Error_o), 32'd1);
    reset = 0;
    step();
    check("lit_err_reset", 32'(Addr_Error_o), 32'd0);
    reset = 1;
    // Run sequentially past the last ROM word.
    begin
      int n;
      n = 0;
      while (PC_o !== 32'h0040_0100 && n < 100) begin
        step();
        n++;
      end
      check("seq_reach_end", 32'(n < 100), 32'd1);
    end
    check("lit_last_instr", IF_ID_Instruction_o, rom[63]);
    check("lit_end_err0", 32'(Addr_Error_o), 32'd0);
    step();
    check("lit_oob_valid", 32'(IF_ID_Valid_o), 32'd0);
    check("lit_oob_instr", IF_ID_Instruction_o, Nop);
    check("lit_oob_err", 32'(Addr_Error_o), 32'd1);
    for (int i = 0; i < 3; i++) step();
    check("lit_oob_sticky", 32'(Addr_Error_o), 32'd1);
    // PC wrap-around.
    Jr_i = 1; Jr_Target_i = 32'hFFFF_FFFC;
    step();
    check("lit_wrap_top", PC_o, 32'hFFFF_FFFC);
    idle();
    step();
    check("lit_wrap_zero", PC_o, 32'h0000_0000);
    step();
    check("lit_wrap_four", PC_o, 32'h0000_0004);
    check("lit_wrap_valid", 32'(IF_ID_Valid_o), 32'd0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
